hack_mem_demux: RTL and testbench
=================================

# hack_mem_demux

Write-side demultiplexer for the Hack data memory map: one CPU write port (outM/addressM/writeM) fans out to RAM16K, the memory-mapped screen, and an error monitor. RAM writes pass straight through in the same cycle. Screen writes go into a small FIFO and drain to the video framebuffer over a valid/ready handshake. It sits between the CPU and the memory subsystem and is the counterpart of the read-side 16-bit select mux that merges RAM/screen/keyboard data back to inM.

## Interface
Parameters:
- DATA_W, 16, data word width.
- FIFO_DEPTH, 4, screen write FIFO entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  DATA_W  write data from CPU (outM).
- address  in  15  word address from CPU (addressM).
- load  in  1  write strobe from CPU (writeM).
- stall  out  1  combinational; CPU must hold address/in/load this cycle.
- ram_load  out  1  combinational RAM16K write enable.
- ram_addr  out  14  address[13:0].
- ram_in  out  DATA_W  equals in.
- scr_valid  out  1  FIFO head valid.
- scr_ready  in  1  framebuffer accepts head.
- scr_addr  out  13  head screen offset (address − 16384).
- scr_data  out  DATA_W  head data.
- fill  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err  out  1  sticky illegal-write flag (see Configuration).
- err_addr  out  15  address of first illegal write.

## Operation
- Decode by address[14:13]: 0x/1x with address[14]=0 → RAM (0–16383); 10 → screen (16384–24575); 11 → keyboard/unmapped (≥24576, read-only).
- RAM: ram_load = load & ~address[14]; never stalls; no state.
- Screen push: when load & screen range & fill<FIFO_DEPTH, the entry {address[12:0], in} is written at the edge. When fill==FIFO_DEPTH, stall=1 and nothing is pushed; no pass-through of the pop slot. stall=0 in every other case.
- Screen pop: when scr_valid & scr_ready, the head advances at the edge.
- Simultaneous push and pop: both take effect; fill is unchanged.
- Pointers wrap modulo FIFO_DEPTH; fill saturates by construction, with no overflow or underflow.
- Illegal write (load & address ≥ 24576): no RAM or screen side effect. Sets err at the next edge. On the first occurrence, err_addr captures address. err clears only on reset.
- scr_valid = (fill≠0); scr_addr/scr_data are registered head contents and are stable while scr_valid & ~scr_ready.

## Timing
- RAM path: 0-cycle, purely combinational.
- Screen path latency: write accepted at edge N → scr_valid=1 at N (visible in cycle N+1), no bypass when empty.
- Throughput: one push and one pop per cycle.
- Reset (synchronous, mid-operation included): fill=0, scr_valid=0, pointers=0, err=0, err_addr=0. Pending FIFO entries are discarded. scr_addr/scr_data are don't-care while scr_valid=0. stall reflects current inputs (0 after reset unless FIFO full, which it cannot be).
- Load asserted in the reset cycle: RAM write still occurs (combinational), and no screen push or error capture occurs.

## Configuration
- HACK_MEMDEMUX_ERR_CAPTURE_EN defined: err/err_addr are implemented as described.
- Not defined: err and err_addr are tied to 0, no capture registers exist, and illegal writes are still silently dropped.

## Test plan
- RAM write: load=1, address=100, in=0x1234 → ram_load=1, ram_addr=100, ram_in=0x1234, stall=0, fill stays 0.
- Screen single: load=1, address=16384+5, in=0xFFFF, scr_ready=0 → next cycle scr_valid=1, scr_addr=5, scr_data=0xFFFF, fill=1. Held until scr_ready=1, then fill=0.
- Full/stall: scr_ready=0, 5 back-to-back screen writes → first 4 accepted (fill=4), stall=1 on the 5th. Raise scr_ready → 5th accepted the following cycle, order preserved (scr_data sequence matches write order).
- Simultaneous push/pop at fill=2 → fill stays 2. Drain shows FIFO order across pointer wrap (≥8 entries streamed).
- Illegal: write address=24576 then 30000 → err=1 after first edge, err_addr=24576 unchanged by second write, no ram_load, fill unchanged. With macro undefined, err stays 0.
- Reset mid-stream at fill=3 → next cycle fill=0, scr_valid=0, err=0.

Source files
------------

// File: rtl/hack_mem_demux.sv
// Write-side demultiplexer for the Hack data memory map: RAM16K pass-through,
// screen write FIFO with valid/ready drain, optional illegal-write monitor (HACK_MEMDEMUX_ERR_CAPTURE_EN).
module hack_mem_demux #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in,
  input  logic [14:0]                   address,
  input  logic                          load,
  output logic                          stall,
  output logic                          ram_load,
  output logic [13:0]                   ram_addr,
  output logic [DATA_W-1:0]             ram_in,
  output logic                          scr_valid,
  input  logic                          scr_ready,
  output logic [12:0]                   scr_addr,
  output logic [DATA_W-1:0]             scr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          err,
  output logic [14:0]                   err_addr
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int ENT_W  = 13 + DATA_W;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  logic                 is_ram;
  logic                 is_scr;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;

  // address[14]=0 is RAM; 10 is screen; 11 is keyboard/unmapped and read-only.
  assign is_ram    = ~address[14];
  assign is_scr    = (address[14:13] == 2'b10);
  assign fifo_full = (fill_q == FILL_FULL);

  assign ram_load  = load & is_ram;
  assign ram_addr  = address[13:0];
  assign ram_in    = in;

  // No pass-through of the pop slot: a full FIFO stalls even if it drains this cycle.
  assign stall     = load & is_scr & fifo_full;
  assign push      = load & is_scr & ~fifo_full & ~reset;
  assign pop       = scr_valid & scr_ready;

  assign scr_valid = (fill_q != '0);
  assign {scr_addr, scr_data} = mem_q[rd_ptr_q];
  assign fill      = fill_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      mem_d[wr_ptr_q] = {address[12:0], in};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Entry storage is not reset; it is only observable while scr_valid is high.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

`ifdef HACK_MEMDEMUX_ERR_CAPTURE_EN
  logic        ill_wr;
  logic        err_q, err_d;
  logic [14:0] err_addr_q, err_addr_d;

  assign ill_wr = load & (address[14:13] == 2'b11);

  // Sticky flag; the address is captured only on the first illegal write.
  always_comb begin
    err_d      = err_q | ill_wr;
    err_addr_d = err_addr_q;
    if (ill_wr && !err_q) begin
      err_addr_d = address;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_hack_mem_demux.sv
// Self-checking bench for hack_mem_demux: per-cycle reference model with a
// scoreboard queue of expected screen entries, plus directed boundary checks.
module tb_hack_mem_demux;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
`ifdef HACK_MEMDEMUX_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic [14:0]       address;
  logic              load;
  logic              stall;
  logic              ram_load;
  logic [13:0]       ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic              scr_valid;
  logic              scr_ready;
  logic [12:0]       scr_addr;
  logic [DATA_W-1:0] scr_data;
  logic [2:0]        fill;
  logic              err;
  logic [14:0]       err_addr;

  hack_mem_demux #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in_data), .address(address), .load(load),
    .stall(stall), .ram_load(ram_load), .ram_addr(ram_addr), .ram_in(ram_in),
    .scr_valid(scr_valid), .scr_ready(scr_ready), .scr_addr(scr_addr),
    .scr_data(scr_data), .fill(fill), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, updated once per cycle at the falling edge.
  logic [28:0] sb_q[$];
  int          m_fill     = 0;
  bit          m_err      = 1'b0;
  logic [14:0] m_err_addr = '0;
  bit          armed      = 1'b0;
  bit          last_acc   = 1'b0;
  bit          last_stall = 1'b0;
  int          pops       = 0;

  always @(negedge clk) begin
    bit m_scr, m_ill, m_ram, exp_stall, m_push, m_pop;
    m_ram     = (address[14] == 1'b0);
    m_scr     = (address[14:13] == 2'b10);
    m_ill     = (address[14:13] == 2'b11);
    exp_stall = load && m_scr && (m_fill == DEPTH);
    m_push    = load && m_scr && !exp_stall && !reset;
    m_pop     = (m_fill != 0) && scr_ready;
    if (armed) begin
      check("stall",     stall,     exp_stall);
      check("ram_load",  ram_load,  load && m_ram);
      check("ram_addr",  ram_addr,  address[13:0]);
      check("ram_in",    ram_in,    in_data);
      check("fill",      fill,      m_fill);
      check("scr_valid", scr_valid, m_fill != 0);
      if (m_fill != 0) begin
        check("scr_addr", scr_addr, sb_q[0][28:16]);
        check("scr_data", scr_data, sb_q[0][15:0]);
      end
      check("err",      err,      m_err & ERR_EN);
      check("err_addr", err_addr, ERR_EN ? m_err_addr : 15'd0);
    end
    if (reset) begin
      sb_q.delete();
      m_fill     = 0;
      m_err      = 1'b0;
      m_err_addr = '0;
      armed      = 1'b1;
    end else begin
      if (m_pop) begin
        void'(sb_q.pop_front());
        pops++;
      end
      if (m_push) sb_q.push_back({address[12:0], in_data});
      m_fill = sb_q.size();
      if (load && m_ill) begin
        if (!m_err) m_err_addr = address;
        m_err = 1'b1;
      end
    end
    last_acc   = load && !exp_stall;
    last_stall = exp_stall;
  end

  // Present one write and hold it until the model says it was consumed.
  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    int n;
    address = a;
    in_data = d;
    load    = 1'b1;
    n       = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!last_acc && n < 50);
    if (n >= 50) check("write_timeout", 32'd0, 32'd1);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    load = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; address = '0; in_data = '0; scr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_fill", fill, 0);
    check("rst_valid", scr_valid, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);

    // RAM write passes straight through.
    cpu_write(15'd100, 16'h1234);
    check("ram_fill", fill, 0);
    idle(1);

    // Single screen write, held until ready.
    cpu_write(15'd16389, 16'hFFFF);
    check("scr1_fill", fill, 1);
    check("scr1_addr", scr_addr, 5);
    idle(3);
    check("scr1_hold", scr_data, 16'hFFFF);
    scr_ready = 1'b1;
    idle(1);
    scr_ready = 1'b0;
    check("scr1_drain", fill, 0);

    // Fill to capacity; fifth write stalls until ready rises.
    for (int i = 0; i < 4; i++) cpu_write(15'(16384 + 10 + i), 16'(16'hA000 + i));
    check("full_fill", fill, 4);
    fork
      cpu_write(15'd16398, 16'hA004);
      begin
        @(posedge clk); @(posedge clk); #1;
        check("full_stall", stall, 1);
        scr_ready = 1'b1;
      end
    join
    idle(6);
    check("full_drain", fill, 0);

    // Simultaneous push/pop at fill=2 streams entries across pointer wrap.
    scr_ready = 1'b0;
    cpu_write(15'd16500, 16'h0B00);
    cpu_write(15'd16501, 16'h0B01);
    scr_ready = 1'b1;
    for (int i = 0; i < 10; i++) cpu_write(15'(16502 + i), 16'(16'h0B02 + i));
    check("pp_fill", fill, 2);
    idle(3);
    check("pp_drain", fill, 0);
    scr_ready = 1'b0;

    // Illegal writes: first address captured, second ignored.
    cpu_write(15'd24576, 16'h5555);
    check("ill_err", err, ERR_EN);
    check("ill_addr", err_addr, ERR_EN ? 15'd24576 : 15'd0);
    cpu_write(15'd30000, 16'h6666);
    check("ill_addr2", err_addr, ERR_EN ? 15'd24576 : 15'd0);
    check("ill_fill", fill, 0);

    // Reset mid-stream with a RAM write in the reset cycle.
    for (int i = 0; i < 3; i++) cpu_write(15'(20000 + i), 16'(16'hC000 + i));
    check("mid_fill", fill, 3);
    reset = 1'b1; load = 1'b1; address = 15'd16390; in_data = 16'hDEAD;
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;
    check("mrst_fill", fill, 0);
    check("mrst_valid", scr_valid, 0);
    check("mrst_err", err, 0);

    // Random traffic; inputs held while the model predicts a stall.
    for (int c = 0; c < 400; c++) begin
      if (!last_stall) begin
        load = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0, 1:    address = 15'($urandom_range(0, 16383));
          5:       address = 15'($urandom_range(24576, 32767));
          default: address = 15'($urandom_range(16384, 24575));
        endcase
        in_data = 16'($urandom);
      end
      scr_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    load = 1'b0;
    scr_ready = 1'b1;
    idle(8);
    check("final_fill", fill, 0);
    check("final_valid", scr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
